// File: rtl/tanh_eval_pkg.sv
// Shared types and constants for the 4-bit tanh approximation error evaluator.
// The exact table is min(15, round(16*tanh(code/4))) for codes 0..15.
package tanh_eval_pkg;

    localparam int CODE_W = 4;
    localparam int SUM_W  = 8;
    localparam int SSUM_W = 9;

    // Enumerators carry an ST_ prefix so they never collide with the SETTLE parameter.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } eval_state_t;

    localparam logic [CODE_W-1:0] EXACT_LUT [16] = '{
        4'd0,  4'd4,  4'd7,  4'd10, 4'd12, 4'd14, 4'd14, 4'd15,
        4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15
    };

endpackage

// File: rtl/tanh_ref_lut.sv
// Combinational reference: maps a Q2.2 input code to the exact rounded Q0.4 tanh value.
module tanh_ref_lut
    import tanh_eval_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] exact
);

    assign exact = EXACT_LUT[code];

endmodule

// File: rtl/tanh_err_eval.sv
// Sweeps all 16 codes through an external tanh approximation and accumulates
// error metrics against the exact table.
module tanh_err_eval
    import tanh_eval_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [CODE_W-1:0]        dut_in,
    input  logic [CODE_W-1:0]        dut_out,
    output logic                     busy,
    output logic                     done,
    output logic [4:0]               err_cnt,
    output logic [CODE_W-1:0]        max_abs_err,
    output logic [CODE_W-1:0]        worst_in,
    output logic [SUM_W-1:0]         sum_abs_err,
    output logic signed [SSUM_W-1:0] sum_err
);

    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    // With no settle time the sweep goes straight from one sample to the next.
    localparam eval_state_t AFTER_CODE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    eval_state_t       state, next_state;
    logic [CODE_W-1:0] idx;
    logic [3:0]        cnt;
    logic [CODE_W-1:0] exact;
    logic [4:0]        err;
    logic [CODE_W-1:0] abs_err;

    tanh_ref_lut u_ref (
        .code  (idx),
        .exact (exact)
    );

    assign err     = {1'b0, dut_out} - {1'b0, exact};
    assign abs_err = err[4] ? 4'(5'd0 - err) : err[3:0];

    assign dut_in = idx;
    assign busy   = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done   = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = AFTER_CODE;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                next_state = (idx == 4'hF) ? ST_DONE : AFTER_CODE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Sweep index, settle counter and accumulators; results hold outside SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            cnt         <= '0;
            err_cnt     <= '0;
            max_abs_err <= '0;
            worst_in    <= '0;
            sum_abs_err <= '0;
            sum_err     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        cnt         <= '0;
                        err_cnt     <= '0;
                        max_abs_err <= '0;
                        worst_in    <= '0;
                        sum_abs_err <= '0;
                        sum_err     <= '0;
                    end
                end
                ST_SETTLE: begin
                    cnt <= (cnt == SETTLE_LAST) ? 4'd0 : cnt + 4'd1;
                end
                ST_SAMPLE: begin
                    err_cnt     <= err_cnt + {4'd0, (err != 5'd0)};
                    sum_abs_err <= sum_abs_err + {4'd0, abs_err};
                    sum_err     <= sum_err + {{4{err[4]}}, err};
                    if (abs_err > max_abs_err) begin
                        max_abs_err <= abs_err;
                        worst_in    <= idx;
                    end
                    if (idx != 4'hF) begin
                        idx <= idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
